// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the feature-map write-back stage:
//   - wb_state_e   : control FSM states (IDLE -> RUN -> DRAIN -> IDLE)
//   - Q_LU..Q_RD   : quadrant codes, q = {row[0], col[0]}
//   - DRAIN_CYCLES : cycles spent in DRAIN while the 3-stage pipeline empties
//   - SAT_MAX/MIN  : signed 16-bit saturation limits for stored activations
// ----------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wb_state_e;

  localparam logic [1:0] Q_LU = 2'd0;
  localparam logic [1:0] Q_RU = 2'd1;
  localparam logic [1:0] Q_LD = 2'd2;
  localparam logic [1:0] Q_RD = 2'd3;

  localparam int DRAIN_CYCLES = 3;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/wb_lane_mask.sv
// ----------------------------------------------------------------------------
// wb_lane_mask
// Combinational lane placement for one activation inside a packed SRAM word.
// Lane L = LANES-1 - ACT_PER_ADDR*ch - q, so channel 0 sits at the top of the
// word and the four quadrants of a channel are adjacent.
// Ports:
//   ch_i   : channel index
//   q_i    : quadrant {row[0], col[0]}
//   val_i  : saturated activation
//   mask_o : active-low bytemask, 0 only at lane L
//   data_o : val_i placed at lane L, every other lane 0
// ----------------------------------------------------------------------------
module wb_lane_mask #(
  parameter int CH_NUM       = 24,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 16,
  parameter int CH_BW        = 5,
  localparam int LANES       = CH_NUM * ACT_PER_ADDR
) (
  input  logic [CH_BW-1:0]            ch_i,
  input  logic [1:0]                  q_i,
  input  logic [BW_PER_ACT-1:0]       val_i,
  output logic [LANES-1:0]            mask_o,
  output logic [LANES*BW_PER_ACT-1:0] data_o
);

  int lane_idx;

  always_comb begin
    lane_idx = (LANES - 1) - ACT_PER_ADDR * int'(ch_i) - int'(q_i);
    mask_o   = '1;
    data_o   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == lane_idx) begin
        mask_o[i]                           = 1'b0;
        data_o[i*BW_PER_ACT +: BW_PER_ACT] = val_i;
      end
    end
  end

endmodule

// File: rtl/fmap_writeback.sv
// ----------------------------------------------------------------------------
// fmap_writeback
// Write-back stage between the convolution accumulator and the activation
// SRAM. One signed accumulator beat per cycle (channel-fastest, raster pixel
// order) goes through ReLU, arithmetic shift and 16-bit saturation, and is
// issued as one masked write into the channel's quadrant lane of a 2x2-pixel
// packed word. No backpressure; gaps in in_valid hold the counters.
//
// Pipeline: S1 capture + ReLU/shift, S2 saturate, S3 address/mask/lane build
// (registered outputs). Beat sampled at edge N+1 -> write visible after N+3.
//
// Build option: WB_RELU_EN -- when defined, negatives clamp to 0 before the
// shift; when undefined, negatives shift and saturate down to -32768.
//
// Ports:
//   clk, srstn          : clock, synchronous active-low reset
//   start               : one-cycle frame start (honoured in IDLE only)
//   in_valid, in_data   : accumulator beat
//   sram_wen            : active-low write enable
//   sram_waddr          : word address (row>>1)*(FMAP_W/2)+(col>>1)
//   sram_wdata          : lane-placed write data, other lanes 0
//   sram_bytemask       : active-low per-activation mask
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
//   dbg_state_o         : current FSM state
// ----------------------------------------------------------------------------
module fmap_writeback
  import wb_pkg::*;
#(
  parameter int CH_NUM       = 24,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 16,
  parameter int ACC_BW       = 32,
  parameter int FRAC_SHIFT   = 8,
  parameter int FMAP_W       = 28,
  parameter int FMAP_H       = 28,
  parameter int ADDR_BW      = 8
) (
  input  logic                                     clk,
  input  logic                                     srstn,
  input  logic                                     start,
  input  logic                                     in_valid,
  input  logic signed [ACC_BW-1:0]                 in_data,
  output logic                                     sram_wen,
  output logic [ADDR_BW-1:0]                       sram_waddr,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]           sram_bytemask,
  output logic                                     busy,
  output logic                                     done,
  output wb_state_e                                dbg_state_o
);

  localparam int LANES  = CH_NUM * ACT_PER_ADDR;
  localparam int CH_BW  = $clog2(CH_NUM);
  localparam int COL_BW = $clog2(FMAP_W);
  localparam int ROW_BW = $clog2(FMAP_H);
  localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'(SAT_MAX);
  localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(SAT_MIN);

  // -------------------------------------------------------------- control
  wb_state_e         state_q, state_d;
  logic [CH_BW-1:0]  ch_q, ch_d;
  logic [COL_BW-1:0] col_q, col_d;
  logic [ROW_BW-1:0] row_q, row_d;
  logic [1:0]        drain_q, drain_d;
  logic              done_q, done_d;
  logic              accept, last_beat;

  assign accept    = (state_q == RUN) && in_valid;
  assign last_beat = accept && (ch_q == CH_BW'(CH_NUM - 1)) &&
                     (col_q == COL_BW'(FMAP_W - 1)) && (row_q == ROW_BW'(FMAP_H - 1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A beat coinciding with start is dropped: only RUN accepts beats.
        if (start) begin
          state_d = RUN;
          ch_d    = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (ch_q == CH_BW'(CH_NUM - 1)) begin
            ch_d = '0;
            if (col_q == COL_BW'(FMAP_W - 1)) begin
              col_d = '0;
              row_d = (row_q == ROW_BW'(FMAP_H - 1)) ? '0 : row_q + ROW_BW'(1);
            end else begin
              col_d = col_q + COL_BW'(1);
            end
          end else begin
            ch_d = ch_q + CH_BW'(1);
          end
          if (last_beat) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= IDLE;
      ch_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // ------------------------------------------------------- S1: ReLU/shift
  logic signed [ACC_BW-1:0] relu_val, shift_val;

  always_comb begin
`ifdef WB_RELU_EN
    relu_val = in_data[ACC_BW-1] ? '0 : in_data;
`else
    relu_val = in_data;
`endif
    shift_val = relu_val >>> FRAC_SHIFT;
  end

  logic                     s1_vld_q;
  logic signed [ACC_BW-1:0] s1_val_q;
  logic [CH_BW-1:0]         s1_ch_q;
  logic [COL_BW-1:0]        s1_col_q;
  logic [ROW_BW-1:0]        s1_row_q;

  // ------------------------------------------------------- S2: saturate
  logic [BW_PER_ACT-1:0] sat_val;

  always_comb begin
    if (s1_val_q > SAT_HI)      sat_val = BW_PER_ACT'(SAT_HI);
    else if (s1_val_q < SAT_LO) sat_val = BW_PER_ACT'(SAT_LO);
    else                        sat_val = s1_val_q[BW_PER_ACT-1:0];
  end

  logic                  s2_vld_q;
  logic [BW_PER_ACT-1:0] s2_val_q;
  logic [CH_BW-1:0]      s2_ch_q;
  logic [COL_BW-1:0]     s2_col_q;
  logic [ROW_BW-1:0]     s2_row_q;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      s1_vld_q <= 1'b0;
      s1_val_q <= '0;
      s1_ch_q  <= '0;
      s1_col_q <= '0;
      s1_row_q <= '0;
      s2_vld_q <= 1'b0;
      s2_val_q <= '0;
      s2_ch_q  <= '0;
      s2_col_q <= '0;
      s2_row_q <= '0;
    end else begin
      s1_vld_q <= accept;
      s1_val_q <= shift_val;
      s1_ch_q  <= ch_q;
      s1_col_q <= col_q;
      s1_row_q <= row_q;
      s2_vld_q <= s1_vld_q;
      s2_val_q <= sat_val;
      s2_ch_q  <= s1_ch_q;
      s2_col_q <= s1_col_q;
      s2_row_q <= s1_row_q;
    end
  end

  // ------------------------------------------------- S3: address/mask/lane
  logic [1:0]                  s2_quad;
  logic [LANES-1:0]            lm_mask;
  logic [LANES*BW_PER_ACT-1:0] lm_data;
  int                          addr_full;

  assign s2_quad = {s2_row_q[0], s2_col_q[0]};

  always_comb begin
    addr_full = int'(s2_row_q >> 1) * (FMAP_W / 2) + int'(s2_col_q >> 1);
  end

  wb_lane_mask #(
    .CH_NUM       (CH_NUM),
    .ACT_PER_ADDR (ACT_PER_ADDR),
    .BW_PER_ACT   (BW_PER_ACT),
    .CH_BW        (CH_BW)
  ) u_lane_mask (
    .ch_i   (s2_ch_q),
    .q_i    (s2_quad),
    .val_i  (s2_val_q),
    .mask_o (lm_mask),
    .data_o (lm_data)
  );

  logic                        wen_q;
  logic [ADDR_BW-1:0]          waddr_q;
  logic [LANES*BW_PER_ACT-1:0] wdata_q;
  logic [LANES-1:0]            mask_q;

  // Address and data hold between writes; only the mask returns to all ones.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      wen_q   <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      mask_q  <= '1;
    end else begin
      wen_q <= ~s2_vld_q;
      if (s2_vld_q) begin
        waddr_q <= ADDR_BW'(addr_full);
        wdata_q <= lm_data;
        mask_q  <= lm_mask;
      end else begin
        mask_q <= '1;
      end
    end
  end

  assign sram_wen      = wen_q;
  assign sram_waddr    = waddr_q;
  assign sram_wdata    = wdata_q;
  assign sram_bytemask = mask_q;

endmodule

// File: tb/tb_fmap_writeback.sv
// ----------------------------------------------------------------------------
// tb_fmap_writeback
// Bench for fmap_writeback on a 4x4x24 map. Beats carry random data with a
// few directed values; a reference model derives each write's cycle, address,
// lane and value from the beat index, and a negedge monitor scores every
// cycle of SRAM traffic against the expected queue. Honours WB_RELU_EN.
// ----------------------------------------------------------------------------
module tb_fmap_writeback;
  import wb_pkg::*;

  localparam int CH    = 24;
  localparam int APA   = 4;
  localparam int BW    = 16;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int AB    = 8;
  localparam int LANES = CH * APA;
  localparam int BEATS = W * H * CH;

  // ---------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic srstn = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic signed [31:0] in_data = '0;

  logic                  sram_wen;
  logic [AB-1:0]         sram_waddr;
  logic [LANES*BW-1:0]   sram_wdata;
  logic [LANES-1:0]      sram_bytemask;
  logic                  busy, done;
  wb_state_e             dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  fmap_writeback #(
    .CH_NUM(CH), .ACT_PER_ADDR(APA), .BW_PER_ACT(BW), .ACC_BW(32),
    .FRAC_SHIFT(8), .FMAP_W(W), .FMAP_H(H), .ADDR_BW(AB)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .in_valid(in_valid),
    .in_data(in_data), .sram_wen(sram_wen), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .sram_bytemask(sram_bytemask),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  bit mon_en = 1'b0;
  logic [AB-1:0] mon_last_addr = '0;

  // {expected cycle[63:32], addr[31:24], lane[23:16], value[15:0]}
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------------------------------------------- reference model
  function automatic logic [15:0] model_val(input logic [31:0] d);
    longint v;
    v = longint'($signed(d));
`ifdef WB_RELU_EN
    if (v < 0) v = 0;
`endif
    // floor division by 2^8
    if (v >= 0) v = v / 256;
    else        v = -((-v + 255) / 256);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [LANES-1:0] exp_mask(input int lane);
    logic [LANES-1:0] m;
    m = '1;
    m[lane] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] data_for(input int k);
    case (k)
      0:   return 32'h0000_1200;
      7:   return 32'hFFFF_0000;
      143: return 32'h7FFF_FFFF;  // row1 col1 ch23
      default: begin
        case ($urandom_range(0, 3))
          0:       return $urandom();
          1:       return $urandom_range(0, 32'h00FF_FFFF);
          2:       return 32'(-int'($urandom_range(0, 32'h0010_0000)));
          default: return ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0080_0000;
        endcase
      end
    endcase
  endfunction

  // ---------------------------------------------------- monitor
  logic [63:0]        mon_e;
  int                 mon_lane;
  logic [LANES*BW-1:0] lane_bits;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sram_wen === 1'b0) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("spur_wen", sram_wen, 1);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_lane = int'(mon_e[23:16]);
          check("wr_cyc", cyc, mon_e[63:32]);
          check("waddr", sram_waddr, mon_e[31:24]);
          check("bmask", sram_bytemask, exp_mask(mon_lane));
          check("lane_val", sram_wdata[mon_lane*BW +: BW], mon_e[15:0]);
          lane_bits = '0;
          lane_bits[mon_lane*BW +: BW] = '1;
          check("wd_rest", |(sram_wdata & ~lane_bits), 0);
          mon_last_addr = mon_e[31:24];
        end
      end else begin
        check("idle_wen", sram_wen, 1);
        check("idle_mask", sram_bytemask, {LANES{1'b1}});
        check("idle_addr", sram_waddr, mon_last_addr);
        if (exp_q.size() > 0 && int'(exp_q[0][63:32]) < cyc) begin
          check("missed_wr", sram_wen, 0);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int k, input logic [31:0] d);
    int ch, pix, col, row, q, lane, addr;
    ch   = k % CH;
    pix  = k / CH;
    col  = pix % W;
    row  = pix / W;
    q    = (row % 2) * 2 + (col % 2);
    lane = LANES - 1 - APA * ch - q;
    addr = (row / 2) * (W / 2) + col / 2;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back({32'(cyc + 3), 8'(addr), 8'(lane), model_val(d)});
    tick();
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      // start during RUN must be ignored
      start = ($urandom_range(0, 7) == 0);
      tick();
      start = 1'b0;
    end
  endtask

  task automatic run_frame(input int nbeats, input bit full);
    int w0, last_c;
    bit seen;
    w0 = n_writes;
    // beat alongside start in IDLE is dropped
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h7FFF_0000;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("busy_start", busy, 1);
    check("st_run", dbg_state, RUN);
    last_c = 0;
    for (int k = 0; k < nbeats; k++) begin
      if (k < nbeats - 3) gap();
      last_c = cyc;
      drive_beat(k, data_for(k));
    end
    if (full) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (done === 1'b1) seen = 1'b1;
        else tick();
      end
      check("done_seen", done, 1);
      check("done_cyc", cyc, last_c + 4);
      check("busy_done", busy, 0);
      tick();
      check("done_pulse", done, 0);
      check("n_writes", n_writes - w0, BEATS);
      check("q_empty", exp_q.size(), 0);
    end
  endtask

  task automatic mid_reset();
    srstn = 1'b0;
    // writes scheduled after the reset edge must never appear
    while (exp_q.size() > 0 && int'(exp_q[$][63:32]) > cyc) void'(exp_q.pop_back());
    tick();
    mon_last_addr = '0;
    check("rst_wen", sram_wen, 1);
    check("rst_busy", busy, 0);
    check("rst_st", dbg_state, IDLE);
    tick();
    srstn = 1'b1;
    repeat (4) tick();
    check("rst_q_empty", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------- main sequence
  initial begin
    srstn = 1'b0;
    repeat (3) tick();
    srstn  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("rst_idle_wen", sram_wen, 1);
      check("rst_idle_mask", sram_bytemask, {LANES{1'b1}});
      check("rst_idle_busy", busy, 0);
      check("rst_idle_done", done, 0);
      tick();
    end
    // beats without start are ignored
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      tick();
      check("no_start_st", dbg_state, IDLE);
    end
    in_valid = 1'b0;
    repeat (4) tick();

    run_frame(BEATS, 1'b1);
    repeat (3) tick();
    run_frame(10, 1'b0);
    mid_reset();
    run_frame(BEATS, 1'b1);
    repeat (5) tick();
    check("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
